// File: rtl/gray_fifo_ctrl.sv
// gray_fifo_ctrl: single-clock FIFO pointer controller for an external
// storage array. Keeps binary and Gray-coded read/write pointers, produces
// storage addresses and the write strobe, and registers full/empty/level.
// Optional feature: define GRAY_FIFO_CTRL_ALMOST_EN to add the registered
// almost_full output and its ALMOST_FULL_LEVEL threshold parameter.
module gray_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4
`ifdef GRAY_FIFO_CTRL_ALMOST_EN
  , parameter int ALMOST_FULL_LEVEL = 2**ADDR_WIDTH - 1
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
`ifdef GRAY_FIFO_CTRL_ALMOST_EN
  output logic                  almost_full,
`endif
  output logic                  empty
);

  localparam int PW = ADDR_WIDTH + 1;

  // Gray pointers of a full FIFO differ exactly in their two top bits.
  localparam logic [PW-1:0] FULL_DIFF = PW'(2'b11) << (PW - 2);

  // Binary to Gray conversion shared by both pointers.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  logic [PW-1:0] wr_bin_r;
  logic [PW-1:0] rd_bin_r;
  logic [PW-1:0] wr_gray_r;
  logic [PW-1:0] rd_gray_r;
  logic [PW-1:0] level_r;
  logic          full_r;
  logic          empty_r;

  logic          push_s;
  logic          pop_s;
  logic [PW-1:0] wr_bin_next_s;
  logic [PW-1:0] rd_bin_next_s;
  logic [PW-1:0] wr_gray_next_s;
  logic [PW-1:0] rd_gray_next_s;
  logic [PW-1:0] level_next_s;
  logic          full_next_s;
  logic          empty_next_s;

`ifdef GRAY_FIFO_CTRL_ALMOST_EN
  logic          almost_full_r;
  logic          almost_full_next_s;
`endif

  // Handshake qualification: no push while full, no pop while empty,
  // and flush suppresses the storage write strobe.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (flush) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = wr_valid && !full_r;
      pop_s  = rd_ready && !empty_r;
    end
  end

  // Next pointer, level and flag values; flush returns everything to reset state.
  always_comb begin
    wr_bin_next_s  = wr_bin_r;
    rd_bin_next_s  = rd_bin_r;
    wr_gray_next_s = wr_gray_r;
    rd_gray_next_s = rd_gray_r;
    level_next_s   = level_r;
    full_next_s    = full_r;
    empty_next_s   = empty_r;
`ifdef GRAY_FIFO_CTRL_ALMOST_EN
    almost_full_next_s = almost_full_r;
`endif
    if (flush) begin
      wr_bin_next_s  = {PW{1'b0}};
      rd_bin_next_s  = {PW{1'b0}};
      wr_gray_next_s = {PW{1'b0}};
      rd_gray_next_s = {PW{1'b0}};
      level_next_s   = {PW{1'b0}};
      full_next_s    = 1'b0;
      empty_next_s   = 1'b1;
`ifdef GRAY_FIFO_CTRL_ALMOST_EN
      almost_full_next_s = 1'b0;
`endif
    end else begin
      wr_bin_next_s  = wr_bin_r + PW'(push_s);
      rd_bin_next_s  = rd_bin_r + PW'(pop_s);
      wr_gray_next_s = bin2gray(wr_bin_next_s);
      rd_gray_next_s = bin2gray(rd_bin_next_s);
      level_next_s   = wr_bin_next_s - rd_bin_next_s;
      empty_next_s   = (wr_gray_next_s == rd_gray_next_s);
      full_next_s    = ((wr_gray_next_s ^ rd_gray_next_s) == FULL_DIFF);
`ifdef GRAY_FIFO_CTRL_ALMOST_EN
      almost_full_next_s = (level_next_s >= PW'(ALMOST_FULL_LEVEL));
`endif
    end
  end

  // Pointer, level and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bin_r  <= {PW{1'b0}};
      rd_bin_r  <= {PW{1'b0}};
      wr_gray_r <= {PW{1'b0}};
      rd_gray_r <= {PW{1'b0}};
      level_r   <= {PW{1'b0}};
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
    end else begin
      wr_bin_r  <= wr_bin_next_s;
      rd_bin_r  <= rd_bin_next_s;
      wr_gray_r <= wr_gray_next_s;
      rd_gray_r <= rd_gray_next_s;
      level_r   <= level_next_s;
      full_r    <= full_next_s;
      empty_r   <= empty_next_s;
    end
  end

`ifdef GRAY_FIFO_CTRL_ALMOST_EN
  // Registered almost-full flag tracking the next level against the threshold.
  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_r <= 1'b0;
    end else begin
      almost_full_r <= almost_full_next_s;
    end
  end

  assign almost_full = almost_full_r;
`endif

  assign wr_en       = push_s;
  assign wr_ready    = !full_r;
  assign rd_valid    = !empty_r;
  assign wr_addr     = wr_bin_r[ADDR_WIDTH-1:0];
  assign rd_addr     = rd_bin_r[ADDR_WIDTH-1:0];
  assign wr_ptr_gray = wr_gray_r;
  assign rd_ptr_gray = rd_gray_r;
  assign level       = level_r;
  assign full        = full_r;
  assign empty       = empty_r;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Testbench for gray_fifo_ctrl (ADDR_WIDTH=2): directed scenarios followed by
// random traffic, all checked against an occupancy-count reference model.
// With GRAY_FIFO_CTRL_ALMOST_EN defined, almost_full (threshold 3) is also checked.
module tb_gray_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MODP  = 2 * DEPTH;
  localparam int ALVL  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic          rd_valid;
  logic          rd_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
`ifdef GRAY_FIFO_CTRL_ALMOST_EN
  logic          almost_full;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: total words written / read, modulo 2*DEPTH.
  int m_w = 0;
  int m_r = 0;

  gray_fifo_ctrl #(
    .ADDR_WIDTH(AW)
`ifdef GRAY_FIFO_CTRL_ALMOST_EN
    , .ALMOST_FULL_LEVEL(ALVL)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray),
    .level(level),
    .full(full),
`ifdef GRAY_FIFO_CTRL_ALMOST_EN
    .almost_full(almost_full),
`endif
    .empty(empty)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_level();
    return (m_w - m_r + MODP) % MODP;
  endfunction

  function automatic logic [31:0] to_gray(input int v);
    logic [31:0] b;
    b = v;
    return b ^ (b >> 1);
  endfunction

  // Compare every registered output with the model.
  task automatic check_state();
    int lv;
    lv = m_level();
    check_eq("level", 32'(level), lv);
    check_eq("full", 32'(full), 32'(lv == DEPTH));
    check_eq("empty", 32'(empty), 32'(lv == 0));
    check_eq("wr_ready", 32'(wr_ready), 32'(lv != DEPTH));
    check_eq("rd_valid", 32'(rd_valid), 32'(lv != 0));
    check_eq("wr_ptr_gray", 32'(wr_ptr_gray), to_gray(m_w));
    check_eq("rd_ptr_gray", 32'(rd_ptr_gray), to_gray(m_r));
    check_eq("wr_addr", 32'(wr_addr), m_w % DEPTH);
    check_eq("rd_addr", 32'(rd_addr), m_r % DEPTH);
`ifdef GRAY_FIFO_CTRL_ALMOST_EN
    check_eq("almost_full", 32'(almost_full), 32'(lv >= ALVL));
`endif
  endtask

  // One clock cycle: drive inputs at negedge, check the write strobe,
  // clock, advance the model, check state at the following negedge.
  task automatic cycle(input logic wv, input logic rr, input logic fl, input logic rs);
    bit push;
    bit pop;
    wr_valid = wv;
    rd_ready = rr;
    flush    = fl;
    reset    = rs;
    #1;
    push = wv && (m_level() < DEPTH) && !fl;
    pop  = rr && (m_level() > 0) && !fl;
    check_eq("wr_en", 32'(wr_en), 32'(push));
    @(posedge clk);
    if (rs || fl) begin
      m_w = 0;
      m_r = 0;
    end else begin
      m_w = (m_w + int'(push)) % MODP;
      m_r = (m_r + int'(pop)) % MODP;
    end
    @(negedge clk);
    check_state();
  endtask

  initial begin
    int prev_wr_addr;
    reset    = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state();
    reset = 1'b0;

    // Fill: Gray pointer steps 001, 011, 010, 110.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("gray_step1", 32'(wr_ptr_gray), 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("gray_step2", 32'(wr_ptr_gray), 32'h3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("gray_step3", 32'(wr_ptr_gray), 32'h2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("gray_step4", 32'(wr_ptr_gray), 32'h6);
    check_eq("full_after4", 32'(full), 32'h1);
    check_eq("level_after4", 32'(level), 32'h4);

    // Full with push held and one pop: only the pop happens, push follows.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("level_pop_at_full", 32'(level), 32'h3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("level_refill", 32'(level), 32'h4);

    // Down to level 2, then sustained push+pop across the pointer wrap.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("level_steady", 32'(level), 32'h2);
    end

    // Drain, pop while empty, then a single push.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("rd_valid_empty", 32'(rd_valid), 32'h0);
    prev_wr_addr = int'(wr_addr);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rd_valid_after_push", 32'(rd_valid), 32'h1);
    check_eq("rd_addr_head", 32'(rd_addr), prev_wr_addr);

    // Level 3, then flush together with push and pop.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("level_pre_flush", 32'(level), 32'h3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("level_flushed", 32'(level), 32'h0);
    check_eq("empty_flushed", 32'(empty), 32'h1);

    // Same scenario with reset.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("level_reset", 32'(level), 32'h0);
    check_eq("wr_gray_reset", 32'(wr_ptr_gray), 32'h0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
